issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 159 +++++++++++++++
 tb/tb_issue_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: busy-table scoreboarding, tag wakeup and oldest-first select.
// Define IQ_WAKEUP_BYPASS_EN to let a writeback make a waiting entry issuable in that same cycle.
module issue_queue #(
    parameter int  IQ_ENTRY                  = 8,
    parameter int  NUM_PHYS_REG              = 64,
    localparam int TAG_W                     = $clog2(NUM_PHYS_REG),
    localparam int IMM_W                     = 12,
    localparam int RENAMED_INSTRUCTION_WIDTH = 8 + TAG_W + 1 + TAG_W + IMM_W + 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [RENAMED_INSTRUCTION_WIDTH-1:0] renamed_i,
    input  logic                                 renamed_v_i,
    output logic                                 issue_rename_ready_o,
    output logic [RENAMED_INSTRUCTION_WIDTH-1:0] issued_o,
    output logic                                 issued_v_o,
    input  logic                                 exec_ready_i,
    input  logic                                 wb_v_i,
    input  logic [TAG_W-1:0]                     wb_tag_i,
    input  logic                                 commit_v_i,
    input  logic                                 mispredict_i
);

    localparam int IDX_W = $clog2(IQ_ENTRY);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [7:0]       opcode;
        logic [TAG_W-1:0] dest_id;
        logic             w_v;
        logic [TAG_W-1:0] source_1;
        logic [IMM_W-1:0] source2_imm;
        logic             imm;
    } renamed_instruction_t;

    renamed_instruction_t r_entry [IQ_ENTRY];
    logic [IQ_ENTRY-1:0]  r_older [IQ_ENTRY];
    logic [IQ_ENTRY-1:0]  r_valid;
    logic [IQ_ENTRY-1:0]  r_src1_rdy;
    logic [IQ_ENTRY-1:0]  r_src2_rdy;
    logic [NUM_PHYS_REG-1:0] r_busy;
    logic [CNT_W-1:0]     r_count;

    renamed_instruction_t w_in;
    logic                 w_flush;
    logic                 w_enq;
    logic                 w_deq;
    logic [IDX_W-1:0]     w_enq_idx;
    logic                 w_enq_s1;
    logic                 w_enq_s2;
    logic [IQ_ENTRY-1:0]  w_wake1;
    logic [IQ_ENTRY-1:0]  w_wake2;
    logic [IQ_ENTRY-1:0]  w_elig;
    logic [IQ_ENTRY-1:0]  w_older_elig;
    logic [IQ_ENTRY-1:0]  w_sel_oh;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_sel_any;

    assign w_in    = renamed_i;
    assign w_flush = commit_v_i & mispredict_i;

    assign issue_rename_ready_o = (r_count < CNT_W'(IQ_ENTRY)) & ~w_flush;
    assign w_enq = renamed_v_i & issue_rename_ready_o;

    assign w_enq_s1 = ~r_busy[w_in.source_1] | (wb_v_i & (wb_tag_i == w_in.source_1));
    assign w_enq_s2 = w_in.imm | ~r_busy[w_in.source2_imm[TAG_W-1:0]]
                    | (wb_v_i & (wb_tag_i == w_in.source2_imm[TAG_W-1:0]));

    always_comb begin
        w_enq_idx = '0;
        for (int i = IQ_ENTRY - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_enq_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < IQ_ENTRY; i++) begin
            w_wake1[i] = wb_v_i & r_valid[i] & (r_entry[i].source_1 == wb_tag_i);
            w_wake2[i] = wb_v_i & r_valid[i] & ~r_entry[i].imm
                       & (r_entry[i].source2_imm[TAG_W-1:0] == wb_tag_i);
        end
    end

`ifdef IQ_WAKEUP_BYPASS_EN
    assign w_elig = r_valid & (r_src1_rdy | w_wake1) & (r_src2_rdy | w_wake2);
`else
    assign w_elig = r_valid & r_src1_rdy & r_src2_rdy;
`endif

    // r_older[j][i] means j was allocated before i; an entry wins only if no older entry is eligible.
    always_comb begin
        w_older_elig = '0;
        for (int i = 0; i < IQ_ENTRY; i++) begin
            for (int j = 0; j < IQ_ENTRY; j++) begin
                if (w_elig[j] && r_older[j][i]) w_older_elig[i] = 1'b1;
            end
        end
    end

    assign w_sel_oh  = w_elig & ~w_older_elig;
    assign w_sel_any = |w_sel_oh;

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < IQ_ENTRY; i++) begin
            if (w_sel_oh[i]) w_sel_idx = IDX_W'(i);
        end
    end

    assign issued_v_o = w_sel_any & ~w_flush;
    assign issued_o   = issued_v_o ? r_entry[w_sel_idx] : '0;
    assign w_deq      = issued_v_o & exec_ready_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            r_count    <= '0;
            for (int i = 0; i < IQ_ENTRY; i++) begin
                r_entry[i] <= '0;
                r_older[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_src1_rdy <= r_src1_rdy | w_wake1;
            r_src2_rdy <= r_src2_rdy | w_wake2;
            if (w_deq) r_valid[w_sel_idx] <= 1'b0;
            if (w_enq) begin
                r_valid[w_enq_idx]    <= 1'b1;
                r_entry[w_enq_idx]    <= w_in;
                r_src1_rdy[w_enq_idx] <= w_enq_s1;
                r_src2_rdy[w_enq_idx] <= w_enq_s2;
                r_older[w_enq_idx]    <= '0;
                for (int j = 0; j < IQ_ENTRY; j++) begin
                    r_older[j][w_enq_idx] <= r_valid[j];
                end
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    // A same-cycle allocation of a tag overrides its writeback clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_busy <= '0;
        end else if (w_flush) begin
            r_busy <= '0;
        end else begin
            if (wb_v_i) r_busy[wb_tag_i] <= 1'b0;
            if (w_enq && w_in.w_v) r_busy[w_in.dest_id] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: an age-ordered list model predicts each cycle's outputs.
// Honours IQ_WAKEUP_BYPASS_EN in the same way as the design build.
module tb_issue_queue;

    localparam int IQ_ENTRY     = 8;
    localparam int NUM_PHYS_REG = 64;
    localparam int TAG_W        = 6;
    localparam int IMM_W        = 12;
    localparam int W            = 8 + TAG_W + 1 + TAG_W + IMM_W + 1;
    localparam int S1_LSB       = 1 + IMM_W;
    localparam int WV_BIT       = S1_LSB + TAG_W;
    localparam int DEST_LSB     = WV_BIT + 1;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [W-1:0]     renamed_i;
    logic             renamed_v_i;
    logic             issue_rename_ready_o;
    logic [W-1:0]     issued_o;
    logic             issued_v_o;
    logic             exec_ready_i;
    logic             wb_v_i;
    logic [TAG_W-1:0] wb_tag_i;
    logic             commit_v_i;
    logic             mispredict_i;

    issue_queue #(.IQ_ENTRY(IQ_ENTRY), .NUM_PHYS_REG(NUM_PHYS_REG)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .renamed_i(renamed_i), .renamed_v_i(renamed_v_i),
        .issue_rename_ready_o(issue_rename_ready_o),
        .issued_o(issued_o), .issued_v_o(issued_v_o),
        .exec_ready_i(exec_ready_i),
        .wb_v_i(wb_v_i), .wb_tag_i(wb_tag_i),
        .commit_v_i(commit_v_i), .mispredict_i(mispredict_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [W-1:0] data; bit s1; bit s2; } mentry_t;
    typedef struct { bit v; logic [W-1:0] o; bit rdy; } exp_t;

    mentry_t mq[$];
    exp_t    expq[$];
    bit      busy[NUM_PHYS_REG];
    int      total = 0;
    int      bad   = 0;

    function automatic logic [W-1:0] makeInstr(input logic [7:0] op, input int dest, input bit wv,
                                               input int s1, input logic [IMM_W-1:0] s2imm, input bit imm);
        return {op, TAG_W'(dest), wv, TAG_W'(s1), s2imm, imm};
    endfunction

    function automatic int tagSrc1(input logic [W-1:0] d);
        return int'(d[S1_LSB +: TAG_W]);
    endfunction

    function automatic int tagSrc2(input logic [W-1:0] d);
        return int'(d[1 +: TAG_W]);
    endfunction

    function automatic logic [W-1:0] randInstr();
        logic [IMM_W-1:0] s2imm;
        s2imm = IMM_W'($urandom);
        s2imm[TAG_W-1:0] = TAG_W'($urandom_range(0, 15));
        return makeInstr(8'($urandom), $urandom_range(0, 15), ($urandom % 4) != 0,
                         $urandom_range(0, 15), s2imm, ($urandom % 4) == 0);
    endfunction

    // Predict this cycle's outputs from the current inputs, then advance the model one clock.
    task automatic modelCycle();
        bit      flush;
        bit      rdy;
        bit      m1;
        bit      m2;
        int      sel;
        exp_t    e;
        mentry_t ne;
        flush = commit_v_i && mispredict_i;
        rdy   = (mq.size() < IQ_ENTRY) && !flush;
        sel   = -1;
        if (!flush) begin
            foreach (mq[k]) begin
                m1 = wb_v_i && (tagSrc1(mq[k].data) == int'(wb_tag_i));
                m2 = wb_v_i && !mq[k].data[0] && (tagSrc2(mq[k].data) == int'(wb_tag_i));
`ifdef IQ_WAKEUP_BYPASS_EN
                if (sel < 0 && (mq[k].s1 || m1) && (mq[k].s2 || m2)) sel = k;
`else
                if (sel < 0 && mq[k].s1 && mq[k].s2) sel = k;
`endif
            end
        end
        e.v   = (sel >= 0);
        e.o   = (sel >= 0) ? mq[sel].data : '0;
        e.rdy = rdy;
        expq.push_back(e);
        if (flush) begin
            mq.delete();
            foreach (busy[t]) busy[t] = 0;
        end else begin
            ne.data = renamed_i;
            ne.s1 = !busy[tagSrc1(renamed_i)] || (wb_v_i && int'(wb_tag_i) == tagSrc1(renamed_i));
            ne.s2 = renamed_i[0] || !busy[tagSrc2(renamed_i)]
                 || (wb_v_i && int'(wb_tag_i) == tagSrc2(renamed_i));
            if (sel >= 0 && exec_ready_i) mq.delete(sel);
            foreach (mq[k]) begin
                if (wb_v_i && tagSrc1(mq[k].data) == int'(wb_tag_i)) mq[k].s1 = 1;
                if (wb_v_i && tagSrc2(mq[k].data) == int'(wb_tag_i)) mq[k].s2 = 1;
            end
            if (wb_v_i) busy[wb_tag_i] = 0;
            if (renamed_v_i && rdy) begin
                mq.push_back(ne);
                if (renamed_i[WV_BIT]) busy[renamed_i[DEST_LSB +: TAG_W]] = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit rv, input logic [W-1:0] instr, input bit er,
                                 input bit wbv, input int wbt, input bit cv, input bit mp);
        renamed_v_i  = rv;
        renamed_i    = instr;
        exec_ready_i = er;
        wb_v_i       = wbv;
        wb_tag_i     = TAG_W'(wbt);
        commit_v_i   = cv;
        mispredict_i = mp;
        modelCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyReset();
        exp_t e;
        renamed_v_i  = 0;
        renamed_i    = '0;
        exec_ready_i = 0;
        wb_v_i       = 0;
        wb_tag_i     = '0;
        commit_v_i   = 0;
        mispredict_i = 0;
        reset_i      = 0;
        mq.delete();
        foreach (busy[t]) busy[t] = 0;
        e.v = 0;
        e.o = '0;
        e.rdy = 1;
        expq.push_back(e);
        @(posedge clk_i);
        #1;
        reset_i = 1;
    endtask

    task automatic checkOutput(input exp_t e);
        total += 3;
        if (issued_v_o !== e.v) begin
            bad++;
            $display("[TB] FAIL issued_v_o @%0t got=%0b want=%0b", $time, issued_v_o, e.v);
        end
        if (issued_o !== e.o) begin
            bad++;
            $display("[TB] FAIL issued_o @%0t got=%h want=%h", $time, issued_o, e.o);
        end
        if (issue_rename_ready_o !== e.rdy) begin
            bad++;
            $display("[TB] FAIL ready @%0t got=%0b want=%0b", $time, issue_rename_ready_o, e.rdy);
        end
    endtask

    // Monitor: every expectation belongs to the cycle whose falling edge comes next.
    always @(negedge clk_i) begin
        if (expq.size() > 0) checkOutput(expq.pop_front());
    end

    initial begin
        logic [W-1:0] n;
        reset_i      = 0;
        renamed_v_i  = 0;
        renamed_i    = '0;
        exec_ready_i = 0;
        wb_v_i       = 0;
        wb_tag_i     = '0;
        commit_v_i   = 0;
        mispredict_i = 0;
        n            = '0;
        @(posedge clk_i);
        #1;
        applyReset();

        // ADD p32 <- p1, p2 with both sources free.
        applyStimulus(1, makeInstr(8'h33, 32, 1, 1, 12'd2, 0), 1, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);

        // Producer p40 held at execute, consumer waiting on p40.
        applyStimulus(1, makeInstr(8'h01, 40, 1, 3, 12'd4, 0), 0, 0, 0, 0, 0);
        applyStimulus(1, makeInstr(8'h02, 41, 1, 40, 12'd5, 1), 0, 0, 0, 0, 0);
        applyStimulus(0, n, 0, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 1, 40, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);

        // Fill with a held producer and blocked consumers, then free one slot while enqueuing.
        applyStimulus(1, makeInstr(8'h10, 50, 1, 6, 12'd7, 0), 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1, makeInstr(8'(8'h11 + i), 51 + i, 1, 50, 12'd50, 0), 0, 0, 0, 0, 0);
        applyStimulus(1, makeInstr(8'h20, 60, 1, 50, 12'd1, 1), 1, 0, 0, 0, 0);
        applyStimulus(1, makeInstr(8'h21, 61, 1, 50, 12'd1, 1), 0, 0, 0, 0, 0);
        applyStimulus(0, n, 0, 0, 0, 0, 0);

        // Several consumers wake together and drain oldest-first.
        applyStimulus(0, n, 1, 1, 50, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, n, 1, 0, 0, 0, 0);

        // Flush with a populated queue, and a non-mispredicted commit that must be ignored.
        for (int i = 0; i < 5; i++)
            applyStimulus(1, makeInstr(8'(8'h30 + i), 20 + i, 1, 20 + i, 12'd1, 1), 0, 0, 0, 0, 0);
        applyStimulus(0, n, 0, 0, 0, 1, 0);
        applyStimulus(1, makeInstr(8'h40, 9, 1, 2, 12'd3, 0), 0, 0, 0, 1, 1);
        applyStimulus(1, makeInstr(8'h41, 9, 1, 21, 12'd22, 0), 1, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);

        // Same-cycle writeback of a source tag being enqueued.
        applyStimulus(1, makeInstr(8'h50, 30, 1, 11, 12'd12, 0), 0, 0, 0, 0, 0);
        applyStimulus(1, makeInstr(8'h51, 31, 1, 30, 12'd13, 1), 0, 1, 30, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);
        applyStimulus(0, n, 1, 0, 0, 0, 0);

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                applyStimulus(1, randInstr(), 0, 0, 0, 0, 0);
                applyReset();
            end else begin
                applyStimulus(($urandom % 4) != 0, randInstr(), ($urandom % 4) != 0,
                              ($urandom % 3) == 0, $urandom_range(0, 15),
                              ($urandom % 10) == 0, ($urandom % 4) == 0);
            end
        end

        applyStimulus(0, n, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_i);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
